crc16_serial_checker: RTL and testbench

- Receive-side counterpart of the CRC-16 codeword loader/generator path.
- Accepts a parallel codeword of DATA_W data bits followed by a 16-bit CRC, divides it bit-serially (MSB first) by the generator polynomial, and reports pass/fail, the 16-bit syndrome and the recovered data.
- Sits between the codeword source (VIO/capture register) and downstream consumers; one codeword in flight at a time.

---
 rtl/crc16_serial_checker.sv | 112 +++++++++++
 tb/tb_crc16_serial_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_serial_checker.sv
// CRC-16 serial checker.
// Takes a parallel codeword {data, crc} and divides it MSB first by G(x) = x^16 + POLY.
// When the division finishes it reports the syndrome, a pass/fail flag, the recovered data
// field and a saturating count of failed codewords. Only one codeword is in flight at a time.
module crc16_serial_checker #(
  parameter int unsigned CW_W = 40,
  parameter logic [15:0] POLY = 16'h8005
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CW_W-1:0]    codeword_in,
  output logic               busy,
  output logic               done,
  output logic               crc_ok,
  output logic [15:0]        syndrome,
  output logic [CW_W-17:0]   data_out,
  output logic [15:0]        err_count
);

  localparam int unsigned DataW = CW_W - 16;
  localparam int unsigned CntW  = $clog2(CW_W);
  localparam logic [CntW-1:0] LastCnt = CntW'(CW_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e            state;
  logic [CW_W-1:0]   shift_reg;
  logic [15:0]       rem;
  logic [CntW-1:0]   bit_cnt;
  // Data field copy kept apart from shift_reg, which is consumed during division.
  logic [DataW-1:0]  data_hold;

  logic              accept;
  logic              last_bit;
  logic [15:0]       rem_next;

  // Handshake, end-of-division detect and one long-division step.
  always_comb begin
    accept   = in_valid & in_ready;
    last_bit = (bit_cnt == LastCnt);
    rem_next = {rem[14:0], shift_reg[CW_W-1]} ^ (rem[15] ? POLY : 16'h0000);
  end

  // Control FSM with all datapath state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      shift_reg <= '0;
      rem       <= 16'h0000;
      bit_cnt   <= '0;
      data_hold <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      syndrome  <= 16'h0000;
      data_out  <= '0;
      err_count <= 16'h0000;
    end else begin
      case (state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (accept) begin
            state     <= StShift;
            shift_reg <= codeword_in;
            data_hold <= codeword_in[CW_W-1:16];
            rem       <= 16'h0000;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
          end else begin
            state    <= StIdle;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end

        StShift: begin
          shift_reg <= shift_reg << 1;
          rem       <= rem_next;
          bit_cnt   <= bit_cnt + CntW'(1);
          if (last_bit) begin
            state    <= StDone;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            done     <= 1'b1;
            syndrome <= rem_next;
            crc_ok   <= (rem_next == 16'h0000);
            data_out <= data_hold;
            if ((rem_next != 16'h0000) && (err_count != 16'hFFFF)) begin
              err_count <= err_count + 16'h0001;
            end
          end
        end

        default: begin
          state    <= StIdle;
          busy     <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_serial_checker.sv
// Self-checking bench for crc16_serial_checker: directed cases plus random codewords,
// compared against a textbook polynomial-division reference model.
module tb_crc16_serial_checker;

  localparam int unsigned CW_W = 40;
  localparam int unsigned DW   = CW_W - 16;
  localparam logic [15:0] POLY = 16'h8005;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [CW_W-1:0] codeword_in;
  logic            busy;
  logic            done;
  logic            crc_ok;
  logic [15:0]     syndrome;
  logic [DW-1:0]   data_out;
  logic [15:0]     err_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [15:0]   exp_err  = 16'h0000;
  logic [15:0]   last_syn = 16'h0000;
  logic          last_ok  = 1'b0;
  logic [DW-1:0] last_data = '0;

  crc16_serial_checker #(
    .CW_W (CW_W),
    .POLY (POLY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .codeword_in (codeword_in),
    .busy        (busy),
    .done        (done),
    .crc_ok      (crc_ok),
    .syndrome    (syndrome),
    .data_out    (data_out),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Reference: C(x) mod G(x) by XORing shifted copies of G under each set leading bit.
  function automatic logic [15:0] ref_mod(input logic [CW_W-1:0] cw);
    logic [CW_W-1:0] r;
    logic [CW_W-1:0] g;
    r = cw;
    g = '0;
    g[16:0] = {1'b1, POLY};
    for (int i = CW_W - 1; i >= 16; i--) begin
      if (r[i]) r = r ^ (g << (i - 16));
    end
    return r[15:0];
  endfunction

  function automatic logic [CW_W-1:0] rand_cw();
    logic [63:0] r64;
    r64 = {$urandom(), $urandom()};
    return r64[CW_W-1:0];
  endfunction

  // Build a valid codeword: append the remainder of data*x^16.
  function automatic logic [CW_W-1:0] good_cw(input logic [DW-1:0] d);
    logic [CW_W-1:0] base;
    base = {d, 16'h0000};
    return {d, ref_mod(base)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present cw in the current (ready) cycle, run the division, check the DONE cycle.
  // With junk=1, in_valid stays high with garbage while busy; it must be ignored.
  task automatic send(input logic [CW_W-1:0] cw, input bit junk);
    logic [15:0] syn;
    syn = ref_mod(cw);
    check("ready_before_accept", 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    codeword_in = cw;
    step();
    for (int i = 0; i < int'(CW_W); i++) begin
      check("busy_in_shift", 64'(busy), 64'd1);
      check("ready_low_in_shift", 64'(in_ready), 64'd0);
      check("no_done_in_shift", 64'(done), 64'd0);
      if (junk) begin
        in_valid    = 1'b1;
        codeword_in = rand_cw();
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    if (syn != 16'h0000 && exp_err != 16'hFFFF) exp_err = exp_err + 16'h0001;
    last_syn  = syn;
    last_ok   = (syn == 16'h0000);
    last_data = cw[CW_W-1:16];
    check("done_pulse", 64'(done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd0);
    check("ready_in_done", 64'(in_ready), 64'd1);
    check("syndrome", 64'(syndrome), 64'(last_syn));
    check("crc_ok", 64'(crc_ok), 64'(last_ok));
    check("data_out", 64'(data_out), 64'(last_data));
    check("err_count", 64'(err_count), 64'(exp_err));
    in_valid = 1'b0;
  endtask

  // One idle cycle: no pulse, results held.
  task automatic idle_step();
    in_valid = 1'b0;
    step();
    check("idle_done_low", 64'(done), 64'd0);
    check("idle_ready", 64'(in_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("hold_syndrome", 64'(syndrome), 64'(last_syn));
    check("hold_crc_ok", 64'(crc_ok), 64'(last_ok));
    check("hold_data_out", 64'(data_out), 64'(last_data));
    check("hold_err_count", 64'(err_count), 64'(exp_err));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_crc_ok"}, 64'(crc_ok), 64'd0);
    check({tag, "_syndrome"}, 64'(syndrome), 64'd0);
    check({tag, "_data_out"}, 64'(data_out), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with in_valid high: reset must win over accept.
    reset       = 1'b1;
    in_valid    = 1'b1;
    codeword_in = rand_cw();
    step();
    step();
    check_reset_state("reset");
    reset    = 1'b0;
    in_valid = 1'b0;
    idle_step();

    // Directed cases from the known-answer list.
    send({24'h000000, 16'h0000}, 1'b0);
    check("zero_syndrome", 64'(syndrome), 64'h0000);
    idle_step();
    send({24'h000001, 16'h8005}, 1'b0);
    check("g_itself_ok", 64'(crc_ok), 64'd1);
    idle_step();
    send({24'h000001, 16'h0000}, 1'b0);
    check("x16_syndrome", 64'(syndrome), 64'h8005);
    check("x16_err_count", 64'(err_count), 64'd1);
    send({24'h000001, 16'h8004}, 1'b0);   // back-to-back from DONE
    check("bitflip_syndrome", 64'(syndrome), 64'h0001);
    check("bitflip_err_count", 64'(err_count), 64'd2);
    idle_step();

    // Back-to-back with in_valid held and junk offered while busy, alternating good/bad.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) send(good_cw(DW'($urandom())), 1'b1);
      else            send(rand_cw(), 1'b1);
    end
    idle_step();

    // Random mix with random gaps.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 0) send(good_cw(DW'($urandom())), $urandom_range(0, 1) == 1);
      else                          send(rand_cw(), $urandom_range(0, 1) == 1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_step();
    end

    // Reset 10 cycles into SHIFT: abandoned, everything back to reset values.
    in_valid    = 1'b1;
    codeword_in = {24'hABCDEF, 16'h1234};
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("pre_reset_busy", 64'(busy), 64'd1);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("midreset");
    exp_err   = 16'h0000;
    last_syn  = 16'h0000;
    last_ok   = 1'b0;
    last_data = '0;
    for (int i = 0; i < 45; i++) idle_step();
    send(good_cw(24'h5A5A5A), 1'b0);
    check("after_reset_ok", 64'(crc_ok), 64'd1);
    idle_step();

    // Saturation: preload the counter just below the ceiling.
    force dut.err_count = 16'hFFFE;
    #2;
    release dut.err_count;
    exp_err = 16'hFFFE;
    check("preload", 64'(err_count), 64'hFFFE);
    send({24'h000001, 16'h0000}, 1'b0);
    check("sat_reach", 64'(err_count), 64'hFFFF);
    send({24'h000002, 16'h0000}, 1'b0);
    check("sat_hold", 64'(err_count), 64'hFFFF);
    check("sat_crc_ok", 64'(crc_ok), 64'd0);
    send(good_cw(24'h123456), 1'b0);
    check("sat_good", 64'(err_count), 64'hFFFF);
    idle_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
